// File: rtl/nn_infer_arbiter.sv
// Round-robin scheduler sharing one inference engine between NUM_REQ requesters.
// Define NN_ARB_PERF_EN to build the perf_jobs / perf_last_lat counters.
module nn_infer_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int FEAT_W  = 784,
   parameter int PRED_W  = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                      ACLK,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*FEAT_W-1:0] req_features,
   output logic [NUM_REQ-1:0]        rsp_valid,
   input  logic [NUM_REQ-1:0]        rsp_ready,
   output logic [PRED_W-1:0]         rsp_prediction,
   output logic                      rsp_err,
   output logic                      eng_rst,
   output logic                      eng_start,
   output logic [FEAT_W-1:0]         eng_features,
   input  logic [PRED_W-1:0]         eng_prediction,
   input  logic                      eng_done,
   output logic                      busy,
   output logic [15:0]               perf_jobs,
   output logic [7:0]                perf_last_lat
);

   localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_START,
      S_WAIT,
      S_RESP
   } state_t;

   state_t              state_q, state_d;
   logic [GW-1:0]       last_q, last_d;
   logic [GW-1:0]       grant_q, grant_d;
   logic [FEAT_W-1:0]   feat_q, feat_d;
   logic [CW-1:0]       wcnt_q, wcnt_d;
   logic [PRED_W-1:0]   pred_q, pred_d;
   logic                err_q, err_d;

   logic [GW-1:0]       arb_idx;
   logic                arb_hit;
   logic [GW-1:0]       cand_idx;
   int                  cand;
   logic                leave_wait;
   logic                resp_hs;

   logic [FEAT_W-1:0]   slice [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign slice[gi] = req_features[gi*FEAT_W +: FEAT_W];
   end

   // Descending scan so the candidate nearest to last_grant+1 is written last and wins.
   always_comb begin
      arb_hit  = 1'b0;
      arb_idx  = '0;
      cand     = 0;
      cand_idx = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         cand = int'(last_q) + i;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         cand_idx = GW'(cand);
         if (req_valid[cand_idx]) begin
            arb_hit = 1'b1;
            arb_idx = cand_idx;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      grant_d = grant_q;
      feat_d  = feat_q;
      wcnt_d  = wcnt_q;
      pred_d  = pred_q;
      err_d   = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (arb_hit) begin
               grant_d = arb_idx;
               feat_d  = slice[arb_idx];
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            state_d = S_START;
         end
         S_START: begin
            wcnt_d  = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            wcnt_d = wcnt_q + 1'b1;
            if (eng_done) begin
               pred_d  = eng_prediction;
               err_d   = 1'b0;
               state_d = S_RESP;
            end else if (wcnt_q == CW'(TIMEOUT - 1)) begin
               pred_d  = '0;
               err_d   = 1'b1;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready[grant_q]) begin
               last_d  = grant_q;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge ACLK or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         last_q  <= GW'(NUM_REQ - 1);
         grant_q <= '0;
         feat_q  <= '0;
         wcnt_q  <= '0;
         pred_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         feat_q  <= feat_d;
         wcnt_q  <= wcnt_d;
         pred_q  <= pred_d;
         err_q   <= err_d;
      end
   end

   // Engine controls decode from state alone, so reset drives eng_rst high immediately.
   assign eng_rst        = (state_q == S_IDLE) || (state_q == S_CLEAR);
   assign eng_start      = (state_q == S_START);
   assign eng_features   = feat_q;
   assign busy           = (state_q != S_IDLE);
   assign rsp_prediction = pred_q;
   assign rsp_err        = err_q;
   assign req_ready      = (state_q == S_IDLE && arb_hit)
                           ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << arb_idx) : '0;
   assign rsp_valid      = (state_q == S_RESP)
                           ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q) : '0;

   assign leave_wait = (state_q == S_WAIT) && (state_d == S_RESP);
   assign resp_hs    = (state_q == S_RESP) && rsp_ready[grant_q];

`ifdef NN_ARB_PERF_EN
   logic [15:0] jobs_q;
   logic [7:0]  lat_q;
   logic [7:0]  lat_sat;
   int          lat_full;

   // Latency is the number of WAIT cycles, including the one that leaves WAIT.
   always_comb begin
      lat_full = int'(wcnt_q) + 1;
      lat_sat  = (lat_full > 255) ? 8'hFF : 8'(lat_full);
   end

   always_ff @(posedge ACLK or posedge rst) begin
      if (rst) begin
         jobs_q <= '0;
         lat_q  <= '0;
      end else begin
         if (resp_hs && (jobs_q != 16'hFFFF)) begin
            jobs_q <= jobs_q + 16'd1;
         end
         if (leave_wait) begin
            lat_q <= lat_sat;
         end
      end
   end

   assign perf_jobs     = jobs_q;
   assign perf_last_lat = lat_q;
`else
   logic unused_perf;
   assign unused_perf   = leave_wait ^ resp_hs;
   assign perf_jobs     = '0;
   assign perf_last_lat = '0;
`endif

endmodule

// File: tb/tb_nn_infer_arbiter.sv
// Directed bench for nn_infer_arbiter: table of jobs plus reset-mid-job and perf sequences.
module tb_nn_infer_arbiter;

   localparam int NUM_REQ = 4;
   localparam int FEAT_W  = 784;
   localparam int PRED_W  = 4;
   localparam int TIMEOUT = 64;
   localparam int ENG_LAT = 5;

   logic                      ACLK;
   logic                      rst;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*FEAT_W-1:0] req_features;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [NUM_REQ-1:0]        rsp_ready;
   logic [PRED_W-1:0]         rsp_prediction;
   logic                      rsp_err;
   logic                      eng_rst;
   logic                      eng_start;
   logic [FEAT_W-1:0]         eng_features;
   logic [PRED_W-1:0]         eng_prediction;
   logic                      eng_done = 1'b0;
   logic                      busy;
   logic [15:0]               perf_jobs;
   logic [7:0]                perf_last_lat;

   logic [FEAT_W-1:0]         feat_pat [NUM_REQ];
   logic [PRED_W-1:0]         eng_pred_v;
   logic                      hang;
   logic                      eng_run = 1'b0;
   int                        eng_cnt = 0;

   int n_cmp = 0;
   int n_bad = 0;

   nn_infer_arbiter #(
      .NUM_REQ(NUM_REQ), .FEAT_W(FEAT_W), .PRED_W(PRED_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .ACLK(ACLK), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_features(req_features),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_prediction(rsp_prediction), .rsp_err(rsp_err),
      .eng_rst(eng_rst), .eng_start(eng_start), .eng_features(eng_features),
      .eng_prediction(eng_prediction), .eng_done(eng_done),
      .busy(busy), .perf_jobs(perf_jobs), .perf_last_lat(perf_last_lat)
   );

   initial begin
      ACLK = 1'b0;
      forever #5 ACLK = ~ACLK;
   end

   // Engine model: sticky done ENG_LAT cycles after start, cleared by eng_rst.
   assign eng_prediction = eng_pred_v;
   always @(posedge ACLK) begin
      if (eng_rst) begin
         eng_done <= 1'b0;
         eng_run  <= 1'b0;
         eng_cnt  <= 0;
      end else if (eng_start) begin
         eng_run <= 1'b1;
         eng_cnt <= 1;
      end else if (eng_run) begin
         eng_cnt <= eng_cnt + 1;
         if (eng_cnt + 1 == ENG_LAT && !hang) begin
            eng_done <= 1'b1;
            eng_run  <= 1'b0;
         end
      end
   end

   typedef struct {
      logic [3:0] mask;
      logic [3:0] pred;
      logic       hang;
      int         g;
      logic [3:0] exp_p;
      logic       exp_e;
      int         lat;
      int         hold;
   } job_t;

   job_t vec [11];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic run_job(input int id, input job_t j);
      int n;
      int lat;
      int n_rst;
      int n_st;
      logic [3:0] oh;
      oh         = 4'b0001 << j.g;
      eng_pred_v = j.pred;
      hang       = j.hang;
      req_valid  = j.mask;
      #1;
      n = 0;
      while (req_ready == 0 && n < 20) begin
         @(negedge ACLK); #1;
         n++;
      end
      check("req_ready grant", 32'(req_ready), 32'(oh));
      lat   = 1;
      n_rst = 0;
      n_st  = 0;
      @(negedge ACLK); #1;
      check("eng_features slice", 32'(eng_features === feat_pat[j.g]), 32'd1);
      check("busy in job", 32'(busy), 32'd1);
      while (rsp_valid == 0 && lat < 200) begin
         n_rst += int'(eng_rst);
         n_st  += int'(eng_start);
         @(negedge ACLK); #1;
         lat++;
      end
      check("accept-to-rsp latency", 32'(lat), 32'(j.lat));
      check("eng_rst pulse count", 32'(n_rst), 32'd1);
      check("eng_start pulse count", 32'(n_st), 32'd1);
      check("rsp_valid onehot", 32'(rsp_valid), 32'(oh));
      check("rsp_prediction", 32'(rsp_prediction), 32'(j.exp_p));
      check("rsp_err", 32'(rsp_err), 32'(j.exp_e));
      for (int h = 0; h < j.hold; h++) begin
         rsp_ready = ~oh;
         @(negedge ACLK); #1;
         check("held rsp_valid", 32'(rsp_valid), 32'(oh));
         check("held rsp_prediction", 32'(rsp_prediction), 32'(j.exp_p));
         check("held req_ready", 32'(req_ready), 32'd0);
      end
      $display("job %0d: mask %b grant %0d pred %0d err %0d lat %0d", id, j.mask,
               j.g, rsp_prediction, rsp_err, lat);
      rsp_ready = oh;
      req_valid = '0;
      @(negedge ACLK); #1;
      check("idle after handshake", 32'(busy), 32'd0);
      check("rsp_valid cleared", 32'(rsp_valid), 32'd0);
      rsp_ready = '0;
   endtask

   initial begin
      logic [FEAT_W-1:0] tmp;
      logic [31:0]       chunk;
      int                n;
      logic              saw;
      int                exp_jobs;
      int                exp_lat;

      vec[0]  = '{4'hF, 4'd3,  1'b0, 0, 4'd3,  1'b0, 8,  0};
      vec[1]  = '{4'hF, 4'd9,  1'b0, 1, 4'd9,  1'b0, 8,  0};
      vec[2]  = '{4'hF, 4'd1,  1'b0, 2, 4'd1,  1'b0, 8,  0};
      vec[3]  = '{4'hF, 4'd15, 1'b0, 3, 4'd15, 1'b0, 8,  0};
      vec[4]  = '{4'hF, 4'd5,  1'b0, 0, 4'd5,  1'b0, 8,  0};
      vec[5]  = '{4'h4, 4'd7,  1'b0, 2, 4'd7,  1'b0, 8,  0};
      vec[6]  = '{4'hD, 4'd10, 1'b0, 3, 4'd10, 1'b0, 8,  10};
      vec[7]  = '{4'hF, 4'd11, 1'b1, 0, 4'd0,  1'b1, 67, 0};
      vec[8]  = '{4'h6, 4'd6,  1'b0, 1, 4'd6,  1'b0, 8,  0};
      vec[9]  = '{4'h9, 4'd4,  1'b0, 3, 4'd4,  1'b0, 8,  0};
      vec[10] = '{4'h1, 4'd2,  1'b0, 0, 4'd2,  1'b0, 8,  0};

      for (int k = 0; k < NUM_REQ; k++) begin
         tmp = '0;
         for (int b = 0; b < FEAT_W; b += 32) begin
            chunk = $urandom;
            for (int q = 0; q < 32; q++) begin
               if (b + q < FEAT_W) tmp[b+q] = chunk[q];
            end
         end
         feat_pat[k] = tmp;
         req_features[k*FEAT_W +: FEAT_W] = tmp;
      end

      rst        = 1'b1;
      req_valid  = '0;
      rsp_ready  = '0;
      eng_pred_v = '0;
      hang       = 1'b0;
      #2;
      check("reset busy", 32'(busy), 32'd0);
      check("reset eng_rst", 32'(eng_rst), 32'd1);
      check("reset eng_start", 32'(eng_start), 32'd0);
      check("reset rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset req_ready", 32'(req_ready), 32'd0);
      check("reset eng_features", 32'(eng_features == '0), 32'd1);
      check("reset perf_jobs", 32'(perf_jobs), 32'd0);
      repeat (3) @(negedge ACLK);
      rst = 1'b0;
      @(negedge ACLK); #1;

      for (int i = 0; i < 11; i++) begin
         run_job(i, vec[i]);
      end

      // Reset in the middle of WAIT: no response, clean restart.
      eng_pred_v = 4'd8;
      hang       = 1'b0;
      req_valid  = 4'b0010;
      #1;
      n = 0;
      while (req_ready == 0 && n < 20) begin
         @(negedge ACLK); #1;
         n++;
      end
      check("pre-reset grant", 32'(req_ready), 32'h2);
      @(negedge ACLK);
      req_valid = '0;
      repeat (3) @(negedge ACLK);
      #1;
      check("busy before reset", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check("async reset busy", 32'(busy), 32'd0);
      check("async reset eng_rst", 32'(eng_rst), 32'd1);
      check("async reset rsp_valid", 32'(rsp_valid), 32'd0);
      check("async reset eng_features", 32'(eng_features == '0), 32'd1);
      check("async reset rsp_prediction", 32'(rsp_prediction), 32'd0);
      check("async reset rsp_err", 32'(rsp_err), 32'd0);
      @(negedge ACLK);
      rst = 1'b0;
      saw = 1'b0;
      repeat (12) begin
         @(negedge ACLK); #1;
         if (rsp_valid != 0 || busy) saw = 1'b1;
      end
      check("no response after reset", 32'(saw), 32'd0);

      run_job(11, '{4'h2, 4'd9,  1'b0, 1, 4'd9,  1'b0, 8, 0});
      run_job(12, '{4'h1, 4'd3,  1'b0, 0, 4'd3,  1'b0, 8, 0});
      run_job(13, '{4'h8, 4'd12, 1'b0, 3, 4'd12, 1'b0, 8, 0});

`ifdef NN_ARB_PERF_EN
      exp_jobs = 3;
      exp_lat  = 5;
`else
      exp_jobs = 0;
      exp_lat  = 0;
`endif
      check("perf_jobs", 32'(perf_jobs), 32'(exp_jobs));
      check("perf_last_lat", 32'(perf_last_lat), 32'(exp_lat));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/nn_infer_arbiter.md
Name: nn_infer_arbiter

Overview:
- Round-robin scheduler that shares one NeuralNetwork inference engine between NUM_REQ requesters.
- Sequences each job through the engine: reset pulse, start, wait for done, return result.
- Guards each job with a watchdog timeout.
- Sits between per-requester bus front-ends (AXI4-Lite slaves) and the single engine instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- FEAT_W, 784, feature vector width per request.
- PRED_W, 4, prediction width.
- TIMEOUT, 64, max WAIT cycles before a job is aborted with error (>=2).

Ports:
- ACLK  in  1  clock.
- rst  in  1  reset.
- req_valid  in  NUM_REQ  per-requester job request.
- req_ready  out  NUM_REQ  one-hot accept pulse.
- req_features  in  NUM_REQ*FEAT_W  flattened feature vectors; requester k uses slice [k*FEAT_W +: FEAT_W].
- rsp_valid  out  NUM_REQ  one-hot result valid.
- rsp_ready  in  NUM_REQ  per-requester result accept.
- rsp_prediction  out  PRED_W  result class (shared bus, qualified by rsp_valid).
- rsp_err  out  1  1 = job timed out; rsp_prediction = 0 in that case.
- eng_rst  out  1  engine reset.
- eng_start  out  1  engine start.
- eng_features  out  FEAT_W  latched features of the current job.
- eng_prediction  in  PRED_W  engine result.
- eng_done  in  1  engine completion.
- busy  out  1  a job is in flight (any state other than IDLE).
- perf_jobs  out  16  completed-job counter (optional feature).
- perf_last_lat  out  8  WAIT-cycle count of the last job (optional feature).

Behaviour:
- Reset is asynchronous and active-high: rst, on clock ACLK.
- Reset values: state = IDLE, last_grant = NUM_REQ-1, eng_rst = 1, all other outputs 0, feature register 0.
- States: IDLE, CLEAR, START, WAIT, RESP. All outputs are registered or decoded from state only; no combinational path from req_valid to eng_*.
- IDLE:
  - eng_rst = 1.
  - If any req_valid is high, grant g = first set bit searching upward from last_grant+1, with modulo wrap.
  - Assert req_ready[g] combinationally for this one cycle, latch the slice for g into eng_features, store g, go to CLEAR.
  - The handshake completes in this cycle because req_valid[g] is already high.
- CLEAR: eng_rst = 1 for one cycle (clears the engine's sticky done), go to START.
- START: eng_rst = 0, eng_start = 1 for exactly one cycle, clear wait counter, go to WAIT.
- WAIT:
  - eng_rst = 0, eng_start = 0, counter increments each cycle.
  - If eng_done = 1: latch eng_prediction, rsp_err = 0, go to RESP.
  - Else if counter == TIMEOUT-1: rsp_prediction = 0, rsp_err = 1, go to RESP.
  - eng_done takes priority if both conditions occur in the same cycle.
- RESP:
  - rsp_valid[g] = 1, with rsp_prediction and rsp_err held stable.
  - When rsp_ready[g] = 1: last_grant = g, go to IDLE.
  - rsp_ready on other bits is ignored.
- Latency: req accept to rsp_valid = 3 + engine cycles (5 with the current engine, so 8 cycles total).
- Fairness:
  - A requester that was just served has lowest priority next.
  - With all requesters asserting continuously, grants rotate 0,1,2,3,0,…
- New requests arriving while busy are held off, since req_ready stays 0. Requesters must keep req_valid and features stable until req_ready.
- Deasserting req_valid before grant is legal; the request is simply not seen.
- Reset mid-job: returns to IDLE immediately, no response is issued, eng_rst asserts asynchronously.
- The perf counter saturates at 0xFFFF; perf_last_lat saturates at 0xFF.

Optional Feature:
- NN_ARB_PERF_EN defined:
  - perf_jobs increments on every RESP handshake, including errored jobs.
  - perf_last_lat loads the WAIT counter value on leaving WAIT.
  - Both reset to 0.
- Not defined: perf_jobs and perf_last_lat are constant 0 and no counter logic is synthesized.

Test Plan:
- Single request, requester 2, engine model raising done 5 cycles after start with prediction 7 -> req_ready[2] pulses 1 cycle; eng_rst 1 cycle; eng_start 1 cycle; rsp_valid[2] = 1 with rsp_prediction = 7, rsp_err = 0, 8 cycles after accept.
- All 4 requesters valid continuously, rsp_ready tied 1 -> grant order 0,1,2,3,0; eng_features equals the correct slice for each job.
- Engine never raises done, TIMEOUT = 64 -> rsp_err = 1, rsp_prediction = 0 after 64 WAIT cycles; next request is served normally.
- rsp_ready held 0 for 10 cycles in RESP -> rsp_valid and data stable; no new req_ready while held; release -> returns to IDLE.
- rst asserted during WAIT -> outputs immediately reach reset values; no rsp_valid is issued; a subsequent request completes correctly.
- With NN_ARB_PERF_EN, 3 jobs at 5-cycle engine latency -> perf_jobs = 3, perf_last_lat = 5. Without the macro -> both read 0.
